mdu_sequencer: RTL and testbench
================================

Name: mdu_sequencer

Overview:
Iterative multiply/divide unit with its own sequencing FSM for the multicycle MIPS core. Executes MULT, MULTU, DIV and DIVU one bit per cycle (radix-2) and holds results in internal HI/LO registers. The main controller drives `start` from the R-type funct decode and holds its FSM, keeping `pcen` low, while `busy` is high. MFHI/MFLO read `hi`/`lo` directly; MTHI/MTLO write through this block.

Parameters:
- WIDTH, 32, operand and HI/LO width; iteration count equals WIDTH.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  begin operation; sampled only in IDLE or DONE.
- op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start.
- srca  in  WIDTH  rs value: multiplicand / dividend.
- srcb  in  WIDTH  rt value: multiplier / divisor.
- mthi  in  1  write srca into HI.
- mtlo  in  1  write srca into LO.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse; result is valid in hi/lo.

Behaviour:
- Reset: state=IDLE, hi=0, lo=0, busy=0, done=0, all internal regs 0. Reset mid-operation aborts immediately with the same values; no partial result reaches hi/lo.
- States: IDLE, PREP, RUN, FIX, DONE.
  - IDLE/DONE, start=1 → PREP. Latch op. For signed ops latch |srca|, |srcb| and the result signs; unsigned ops latch raw values. Iteration counter=0.
  - PREP → RUN, 1 cycle. Clear the partial product / partial remainder.
  - RUN: one iteration per cycle. Multiply: add shifted multiplicand if the current multiplier LSB=1, then shift; 2*WIDTH-bit accumulator. Divide: restoring shift-subtract producing one quotient bit. After WIDTH cycles → FIX.
  - FIX → DONE, 1 cycle. Apply sign correction. HI/LO load at the FIX→DONE edge.
  - DONE: done=1 for this cycle only. Then → IDLE, or → PREP if start=1.
- busy=1 in PREP, RUN and FIX; 0 in IDLE and DONE.
- Latency: start high in cycle 0 → PREP cycle 1, RUN cycles 2..WIDTH+1, FIX cycle WIDTH+2, done=1 and new hi/lo in cycle WIDTH+3 (35 for WIDTH=32).
- Multiply result: hi = upper WIDTH bits, lo = lower WIDTH bits. Signed product is negated in FIX when the operand signs differ.
- Divide result: lo = quotient, hi = remainder. Signed quotient truncates toward zero; remainder takes the sign of the dividend.
- Divide by zero (DIV/DIVU, srcb=0): lo = all ones, hi = srca as latched (original signed value). Full latency still applies.
- Signed overflow (most-negative / -1): lo = 0x80000000, hi = 0.
- Ignored inputs: start while busy=1 (no restart, no latch); mthi/mtlo while busy=1.
- mthi/mtlo in IDLE/DONE: the register loads srca at that edge. If both are set, both load srca.
- start together with mthi/mtlo in IDLE/DONE: the write takes effect and the operation begins. The operation result overwrites HI/LO at its own FIX→DONE edge.
- srca/srcb are only required stable in the start cycle.

Optional Feature:
- Macro: MDU_EARLY_TERM_EN.
- Defined: multiply (MULT/MULTU) leaves RUN for FIX at the end of any RUN cycle in which the remaining (post-shift) multiplier bits are all zero. Minimum one RUN cycle. Example: srcb=3 → RUN cycles 2–3, FIX 4, done in cycle 5. srcb=0 → done in cycle 4. Divide is unaffected.
- Undefined: every operation takes exactly WIDTH RUN cycles, i.e. the fixed latency above.

Test Plan:
- MULT srca=0xFFFFFFFF, srcb=7 → done in cycle 35, hi=0xFFFFFFFF, lo=0xFFFFFFF9; busy=1 cycles 1–34 exactly.
- MULTU srca=srcb=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001. With MDU_EARLY_TERM_EN, MULTU 5×3 → done in cycle 5, hi=0, lo=0x0F.
- DIV srca=0xFFFFFFF9 (−7), srcb=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
- DIVU srca=100, srcb=0 → lo=0xFFFFFFFF, hi=0x00000064, done in cycle 35.
- start pulsed again in cycle 10 with different operands, plus mthi=1 in cycle 12 → both ignored; the original result arrives in cycle 35. mthi srca=0x1234 while idle → hi=0x1234 next cycle, lo unchanged.
- reset asserted in cycle 20 of a DIV → next cycle state=IDLE, busy=0, done=0, hi=lo=0. A new start then completes normally at full latency.

Source files
------------

// File: rtl/mdu_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : mdu_sequencer
// Brief   : Radix-2 iterative MULT/MULTU/DIV/DIVU unit with internal HI/LO.
//           Optional macro MDU_EARLY_TERM_EN: multiply leaves RUN once the
//           remaining multiplier bits are all zero.
// Rev     : 1.0 - initial release
// ============================================================================
module mdu_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic             mthi,
  input  logic             mtlo,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  localparam int            c_CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [c_CW-1:0] c_LAST = c_CW'(WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    RUN  = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t             r_state, w_next;
  logic [1:0]         r_op;
  logic               r_neg_q, r_neg_r;
  logic [WIDTH-1:0]   r_a, r_b, r_hi, r_lo;
  logic [2*WIDTH-1:0] r_acc, r_mcand;
  logic [c_CW-1:0]    r_cnt;

  logic               w_idle, w_signed, w_div, w_qbit, w_div0, w_mul_last, w_run_last;
  logic [WIDTH-1:0]   w_abs_a, w_abs_b, w_quo, w_rem;
  logic [WIDTH:0]     w_shift_rem, w_diff;
  logic [2*WIDTH-1:0] w_prod;

  assign w_idle   = (r_state == IDLE) || (r_state == DONE);
  assign w_signed = ~op[0];
  assign w_abs_a  = (w_signed && srca[WIDTH-1]) ? -srca : srca;
  assign w_abs_b  = (w_signed && srcb[WIDTH-1]) ? -srcb : srcb;
  assign w_div    = r_op[1];

  // Restoring divide: r_acc low half is the partial remainder, r_a shifts
  // dividend bits out and quotient bits in.
  assign w_shift_rem = {r_acc[WIDTH-1:0], r_a[WIDTH-1]};
  assign w_diff      = w_shift_rem - {1'b0, r_b};
  assign w_qbit      = ~w_diff[WIDTH];
  assign w_div0      = (r_b == '0);

`ifdef MDU_EARLY_TERM_EN
  assign w_mul_last = ~r_op[1] && (r_b[WIDTH-1:1] == '0);
`else
  assign w_mul_last = 1'b0;
`endif
  assign w_run_last = (r_cnt == c_LAST) || w_mul_last;

  // With a zero divisor the remainder ends up equal to |srca|, so the
  // dividend-sign fixup restores the original srca for HI.
  assign w_prod = r_neg_q ? -r_acc : r_acc;
  assign w_quo  = r_neg_q ? -r_a : r_a;
  assign w_rem  = r_neg_r ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    busy   = 1'b0;
    done   = 1'b0;
    case (r_state)
      IDLE: if (start) w_next = PREP;
      PREP: begin
        busy   = 1'b1;
        w_next = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (w_run_last) w_next = FIX;
      end
      FIX: begin
        busy   = 1'b1;
        w_next = DONE;
      end
      DONE: begin
        done   = 1'b1;
        w_next = start ? PREP : IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_op    <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_mcand <= '0;
      r_cnt   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      if (w_idle && mthi) r_hi <= srca;
      if (w_idle && mtlo) r_lo <= srca;
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_op    <= op;
            r_a     <= w_abs_a;
            r_b     <= w_abs_b;
            r_neg_q <= w_signed & (srca[WIDTH-1] ^ srcb[WIDTH-1]);
            r_neg_r <= w_signed & srca[WIDTH-1];
            r_cnt   <= '0;
          end
        end
        PREP: begin
          r_acc   <= '0;
          r_mcand <= {{WIDTH{1'b0}}, r_a};
        end
        RUN: begin
          r_cnt <= r_cnt + 1'b1;
          if (w_div) begin
            r_acc[WIDTH-1:0] <= w_qbit ? w_diff[WIDTH-1:0] : w_shift_rem[WIDTH-1:0];
            r_a              <= {r_a[WIDTH-2:0], w_qbit};
          end else begin
            if (r_b[0]) r_acc <= r_acc + r_mcand;
            r_mcand <= r_mcand << 1;
            r_b     <= r_b >> 1;
          end
        end
        FIX: begin
          if (w_div) begin
            r_lo <= w_div0 ? '1 : w_quo;
            r_hi <= w_rem;
          end else begin
            r_hi <= w_prod[2*WIDTH-1:WIDTH];
            r_lo <= w_prod[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign hi = r_hi;
  assign lo = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_mdu_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_mdu_sequencer
// Brief   : Self-checking bench for mdu_sequencer (vector table, corner
//           sequences, randomized ops against an arithmetic reference model).
// Rev     : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_mdu_sequencer;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset, start, mthi, mtlo;
  logic [1:0]   op;
  logic [W-1:0] srca, srcb, hi, lo;
  logic         busy, done;

  int           checks   = 0;
  int           failures = 0;
  logic [W-1:0] m_hi, m_lo;

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a, b, eh, el;
  } vec_t;
  vec_t tbl [11];

  mdu_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .srca(srca), .srcb(srcb),
    .mthi(mthi), .mtlo(mtlo), .hi(hi), .lo(lo), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference results straight from the arithmetic definition of each op.
  function automatic void model(input logic [1:0] o, input logic [W-1:0] a, b,
                                output logic [W-1:0] eh, output logic [W-1:0] el);
    logic [63:0] p;
    int sa, sb;
    sa = a;
    sb = b;
    p  = '0;
    eh = '0;
    el = '0;
    case (o)
      2'b00: begin
        p  = {{32{a[31]}}, a} * {{32{b[31]}}, b};
        eh = p[63:32]; el = p[31:0];
      end
      2'b01: begin
        p  = {32'd0, a} * {32'd0, b};
        eh = p[63:32]; el = p[31:0];
      end
      2'b10: begin
        if (b == 0) begin eh = a; el = '1; end
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin eh = 0; el = 32'h8000_0000; end
        else begin el = sa / sb; eh = sa % sb; end
      end
      default: begin
        if (b == 0) begin eh = a; el = '1; end
        else begin el = a / b; eh = a % b; end
      end
    endcase
  endfunction

  // Cycle (counted from the start cycle) in which done is expected.
  function automatic int lat(input logic [1:0] o, input logic [W-1:0] b);
    int runs;
    logic [W-1:0] m;
    runs = W;
    m    = b;
`ifdef MDU_EARLY_TERM_EN
    if (!o[1]) begin
      m    = (!o[0] && b[W-1]) ? -b : b;
      runs = 1;
      while (runs < W && (m >> runs) != 0) runs++;
    end
`endif
    return runs + 3;
  endfunction

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return 32'd1;
      2:       return '1;
      3:       return 32'h8000_0000;
      4:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  task automatic launch(input logic [1:0] o, input logic [W-1:0] a, b);
    start = 1'b1;
    op    = o;
    srca  = a;
    srcb  = b;
  endtask

  // Walks cycles first_k.. until done, scrambling operands every cycle and
  // optionally injecting start/mthi while busy; then checks timing and result.
  task automatic finish_op(input string name, input logic [1:0] o, input logic [W-1:0] b,
                           input logic [W-1:0] eh, input logic [W-1:0] el,
                           input int first_k, input int inj_start, input int inj_mthi);
    int k, exp_lat;
    bit busy_ok, seen;
    exp_lat = lat(o, b);
    busy_ok = 1'b1;
    seen    = 1'b0;
    k       = first_k;
    while (!seen && k <= 80) begin
      @(negedge clk);
      if (done) seen = 1'b1;
      else begin
        if (busy !== 1'b1) busy_ok = 1'b0;
        start = (k == inj_start);
        mthi  = (k == inj_mthi);
        srca  = $urandom;
        srcb  = $urandom;
        op    = 2'($urandom);
        k++;
      end
    end
    start = 1'b0;
    mthi  = 1'b0;
    chk({name, " latency"}, 64'(k), 64'(exp_lat));
    chk({name, " busy_during"}, 64'(busy_ok), 64'd1);
    chk({name, " busy_at_done"}, 64'(busy), 64'd0);
    chk({name, " hi"}, 64'(hi), 64'(eh));
    chk({name, " lo"}, 64'(lo), 64'(el));
    m_hi = eh;
    m_lo = el;
  endtask

  initial begin
    logic [1:0]   ro;
    logic [W-1:0] ra, rb, eh, el;

    tbl[0]  = '{2'b00, 32'hFFFF_FFFF, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFF9};
    tbl[1]  = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    tbl[2]  = '{2'b01, 32'd5,         32'd3,         32'h0,         32'h0000_000F};
    tbl[3]  = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0};
    tbl[4]  = '{2'b00, 32'd3,         32'hFFFF_FFFB, 32'hFFFF_FFFF, 32'hFFFF_FFF1};
    tbl[5]  = '{2'b10, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
    tbl[6]  = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000};
    tbl[7]  = '{2'b11, 32'd100,       32'd0,         32'h0000_0064, 32'hFFFF_FFFF};
    tbl[8]  = '{2'b10, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF};
    tbl[9]  = '{2'b10, 32'd7,         32'hFFFF_FFFE, 32'h1,         32'hFFFF_FFFD};
    tbl[10] = '{2'b11, 32'hFFFF_FFFF, 32'd16,        32'hF,         32'h0FFF_FFFF};

    reset = 1'b1; start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    op = '0; srca = '0; srcb = '0; m_hi = '0; m_lo = '0;
    repeat (3) @(negedge clk);
    chk("reset hi", 64'(hi), 64'd0);
    chk("reset lo", 64'(lo), 64'd0);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 11; i++) begin
      launch(tbl[i].op, tbl[i].a, tbl[i].b);
      finish_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].b, tbl[i].eh, tbl[i].el, 1, 0, 0);
      @(negedge clk);
      chk($sformatf("vec%0d done_pulse", i), 64'(done), 64'd0);
    end

    // start and mthi while busy must both be ignored
    launch(2'b10, 32'd1000, 32'd7);
    finish_op("ignore_busy", 2'b10, 32'd7, 32'd6, 32'd142, 1, 10, 12);
    @(negedge clk);

    // MTHI / MTLO while idle
    mthi = 1'b1; srca = 32'h1234;
    @(negedge clk);
    mthi = 1'b0;
    chk("mthi hi", 64'(hi), 64'h1234);
    chk("mthi lo", 64'(lo), 64'(m_lo));
    mtlo = 1'b1; srca = 32'h5678;
    @(negedge clk);
    mtlo = 1'b0;
    chk("mtlo lo", 64'(lo), 64'h5678);
    chk("mtlo hi", 64'(hi), 64'h1234);
    mthi = 1'b1; mtlo = 1'b1; srca = 32'hABCD;
    @(negedge clk);
    mthi = 1'b0; mtlo = 1'b0;
    chk("mthilo hi", 64'(hi), 64'hABCD);
    chk("mthilo lo", 64'(lo), 64'hABCD);

    // mthi together with start: write lands, then the result overwrites
    launch(2'b01, 32'd6, 32'd7);
    mthi = 1'b1;
    @(negedge clk);
    start = 1'b0; mthi = 1'b0;
    chk("mthi_start hi", 64'(hi), 64'd6);
    finish_op("mthi_start", 2'b01, 32'd7, 32'd0, 32'd42, 2, 0, 0);
    @(negedge clk);

    // reset in cycle 20 of a divide
    launch(2'b10, 32'd12345, 32'd67);
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort busy", 64'(busy), 64'd0);
    chk("abort done", 64'(done), 64'd0);
    chk("abort hi", 64'(hi), 64'd0);
    chk("abort lo", 64'(lo), 64'd0);
    m_hi = '0; m_lo = '0;
    @(negedge clk);
    launch(2'b11, 32'd12345, 32'd67);
    finish_op("after_abort", 2'b11, 32'd67, 32'd17, 32'd184, 1, 0, 0);

    // randomized ops, sometimes chained straight from the DONE cycle
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 1) == 0) begin
        @(negedge clk);
        chk($sformatf("rnd%0d idle", i), {hi, lo}, {m_hi, m_lo});
      end
      ro = 2'($urandom_range(0, 3));
      ra = pick();
      rb = pick();
      model(ro, ra, rb, eh, el);
      launch(ro, ra, rb);
      finish_op($sformatf("rnd%0d op%0d %h %h", i, ro, ra, rb), ro, rb, eh, el, 1, 0, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
